// File: rtl/tlc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tlc_checker
// Purpose  : Passive monitor for the traffic-light controller status bus.
//            It locks onto the first RED/0 sample. After that it predicts
//            every following (state, cnt) sample from the previous one.
//            The legal phase order is RED -> GRN -> YEL -> RED, and each
//            phase lasts RED_T, GRN_T or YEL_T cycles.
//            Any deviation sets a sticky flag, bumps a saturating error
//            counter and drops the checker back to re-synchronisation.
//            Completed YEL->RED wraps are pulsed and counted.
// Ports    : clk        - system clock, posedge
//            rst        - synchronous reset, active-low
//            state[1:0] - controller phase (RED=00, YEL=01, GRN=10, 11 bad)
//            cnt[3:0]   - controller in-phase cycle count
//            armed      - checker synchronised and checking
//            err_seq    - sticky: illegal phase transition
//            err_cnt    - sticky: right phase, wrong count
//            err_state  - sticky: state==2'b11 while checking
//            err_count  - error events, saturating at 255
//            cycle_done - one-cycle pulse per legal YEL->RED wrap
//            cycles     - completed full cycles, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module tlc_checker #(
    parameter int RED_T = 5,
    parameter int GRN_T = 4,
    parameter int YEL_T = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [3:0] cnt,
    output logic       armed,
    output logic       err_seq,
    output logic       err_cnt,
    output logic       err_state,
    output logic [7:0] err_count,
    output logic       cycle_done,
    output logic [7:0] cycles
);

    localparam logic [1:0] c_RED = 2'b00;
    localparam logic [1:0] c_YEL = 2'b01;
    localparam logic [1:0] c_GRN = 2'b10;
    localparam logic [1:0] c_BAD = 2'b11;

    // Last legal cnt value of each phase (dwell - 1)
    localparam logic [3:0] c_RED_LAST = 4'(RED_T - 1);
    localparam logic [3:0] c_GRN_LAST = 4'(GRN_T - 1);
    localparam logic [3:0] c_YEL_LAST = 4'(YEL_T - 1);

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_CHECK = 1'b1
    } fsm_t;

    fsm_t       r_fsm;
    fsm_t       w_fsm_nxt;
    logic [1:0] r_prev_state;
    logic [3:0] r_prev_cnt;
    logic       r_armed;
    logic       r_err_seq;
    logic       r_err_cnt;
    logic       r_err_state;
    logic [7:0] r_err_count;
    logic       r_cycle_done;
    logic [7:0] r_cycles;

    logic [3:0] w_last;
    logic [1:0] w_next_phase;
    logic [1:0] w_exp_state;
    logic [3:0] w_exp_cnt;
    logic       w_is_bad;
    logic       w_seq_bad;
    logic       w_cnt_bad;
    logic       w_error;
    logic       w_match;
    logic       w_arm;
    logic       w_wrap;

    // Prediction of the current sample from the previous accepted one
    always_comb begin
        w_last       = c_RED_LAST;
        w_next_phase = c_GRN;
        case (r_prev_state)
            c_GRN: begin
                w_last       = c_GRN_LAST;
                w_next_phase = c_YEL;
            end
            c_YEL: begin
                w_last       = c_YEL_LAST;
                w_next_phase = c_RED;
            end
            default: begin
                w_last       = c_RED_LAST;
                w_next_phase = c_GRN;
            end
        endcase

        if (r_prev_cnt < w_last) begin
            w_exp_state = r_prev_state;
            w_exp_cnt   = r_prev_cnt + 4'd1;
        end else begin
            w_exp_state = w_next_phase;
            w_exp_cnt   = 4'd0;
        end
    end

    // Errors are classified one per sample, so the lower classes are
    // masked by the higher ones.
    assign w_is_bad  = (state == c_BAD);
    assign w_seq_bad = !w_is_bad && (state != w_exp_state);
    assign w_cnt_bad = !w_is_bad && !w_seq_bad && (cnt != w_exp_cnt);
    assign w_error   = (r_fsm == S_CHECK) && (w_is_bad || w_seq_bad || w_cnt_bad);
    assign w_match   = (r_fsm == S_CHECK) && !(w_is_bad || w_seq_bad || w_cnt_bad);
    assign w_arm     = (r_fsm == S_SYNC) && (state == c_RED) && (cnt == 4'd0);
    assign w_wrap    = w_match && (r_prev_state == c_YEL) && (state == c_RED) && (cnt == 4'd0);

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_SYNC:  if (w_arm)   w_fsm_nxt = S_CHECK;
            S_CHECK: if (w_error) w_fsm_nxt = S_SYNC;
            default: w_fsm_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fsm        <= S_SYNC;
            r_prev_state <= c_RED;
            r_prev_cnt   <= 4'd0;
            r_armed      <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_cnt    <= 1'b0;
            r_err_state  <= 1'b0;
            r_err_count  <= 8'd0;
            r_cycle_done <= 1'b0;
            r_cycles     <= 8'd0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_armed      <= (w_fsm_nxt == S_CHECK);
            r_cycle_done <= w_wrap;
            if (w_arm || w_match) begin
                r_prev_state <= state;
                r_prev_cnt   <= cnt;
            end
            if (w_error) begin
                if (w_is_bad)  r_err_state <= 1'b1;
                if (w_seq_bad) r_err_seq   <= 1'b1;
                if (w_cnt_bad) r_err_cnt   <= 1'b1;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
            if (w_wrap) r_cycles <= r_cycles + 8'd1;
        end
    end

    assign armed      = r_armed;
    assign err_seq    = r_err_seq;
    assign err_cnt    = r_err_cnt;
    assign err_state  = r_err_state;
    assign err_count  = r_err_count;
    assign cycle_done = r_cycle_done;
    assign cycles     = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_tlc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_checker
// Purpose  : Self-checking bench for tlc_checker.
//            dut0 uses the default dwell times. dut1 uses a dwell of 1 for
//            every phase. Both DUTs share the clock, reset and status bus.
//            The variable sel picks which DUT the model and checks follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state = 2'b00;
    logic [3:0] cnt = 4'd0;

    logic       armed0, es0, ec0, est0, done0;
    logic [7:0] ecount0, cyc0;
    logic       armed1, es1, ec1, est1, done1;
    logic [7:0] ecount1, cyc1;

    int         sel = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    tlc_checker dut0 (
        .clk(clk), .rst(rst), .state(state), .cnt(cnt),
        .armed(armed0), .err_seq(es0), .err_cnt(ec0), .err_state(est0),
        .err_count(ecount0), .cycle_done(done0), .cycles(cyc0)
    );

    tlc_checker #(.RED_T(1), .GRN_T(1), .YEL_T(1)) dut1 (
        .clk(clk), .rst(rst), .state(state), .cnt(cnt),
        .armed(armed1), .err_seq(es1), .err_cnt(ec1), .err_state(est1),
        .err_count(ecount1), .cycle_done(done1), .cycles(cyc1)
    );

    // Outputs of the DUT currently under test
    logic       o_armed, o_es, o_ec, o_est, o_done;
    logic [7:0] o_ecount, o_cyc;
    always_comb begin
        o_armed  = (sel == 0) ? armed0  : armed1;
        o_es     = (sel == 0) ? es0     : es1;
        o_ec     = (sel == 0) ? ec0     : ec1;
        o_est    = (sel == 0) ? est0    : est1;
        o_done   = (sel == 0) ? done0   : done1;
        o_ecount = (sel == 0) ? ecount0 : ecount1;
        o_cyc    = (sel == 0) ? cyc0    : cyc1;
    end

    typedef struct packed {
        logic       armed;
        logic       es;
        logic       ec;
        logic       est;
        logic [7:0] ecount;
        logic       done;
        logic [7:0] cyc;
    } exp_t;

    exp_t q[$];

    // Reference model state, written from the behavioural description
    logic       m_armed, m_es, m_ec, m_est, m_done;
    logic [7:0] m_ecount, m_cyc;
    logic [1:0] m_ps;
    logic [3:0] m_pc;
    int         md_r = 5, md_g = 4, md_y = 2;

    function automatic int dur(input logic [1:0] s);
        if (s == 2'b10) return md_g;
        if (s == 2'b01) return md_y;
        return md_r;
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] s);
        if (s == 2'b00) return 2'b10;
        if (s == 2'b10) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input logic r, input logic [1:0] s, input logic [3:0] c);
        logic [1:0] es;
        logic [3:0] ec;
        logic       err;
        if (!r) begin
            m_armed = 0; m_es = 0; m_ec = 0; m_est = 0; m_done = 0;
            m_ecount = 0; m_cyc = 0; m_ps = 0; m_pc = 0;
        end else begin
            m_done = 0;
            if (!m_armed) begin
                if (s == 2'b00 && c == 4'd0) begin
                    m_armed = 1; m_ps = 2'b00; m_pc = 4'd0;
                end
            end else begin
                if (int'(m_pc) < dur(m_ps) - 1) begin
                    es = m_ps; ec = m_pc + 4'd1;
                end else begin
                    es = nxt(m_ps); ec = 4'd0;
                end
                err = 1;
                if (s == 2'b11)   m_est = 1;
                else if (s != es) m_es = 1;
                else if (c != ec) m_ec = 1;
                else err = 0;
                if (err) begin
                    if (m_ecount != 8'd255) m_ecount = m_ecount + 8'd1;
                    m_armed = 0;
                end else begin
                    if (m_ps == 2'b01 && s == 2'b00 && c == 4'd0) begin
                        m_done = 1;
                        m_cyc  = m_cyc + 8'd1;
                    end
                    m_ps = s; m_pc = c;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample and record the prediction. One cycle later, pop the
    // prediction and compare it with the registered outputs.
    task automatic step(input logic r, input logic [1:0] s, input logic [3:0] c);
        exp_t e;
        @(negedge clk);
        rst = r; state = s; cnt = c;
        model(r, s, c);
        e = '{m_armed, m_es, m_ec, m_est, m_ecount, m_done, m_cyc};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("armed",      {7'd0, o_armed}, {7'd0, e.armed});
        chk("err_seq",    {7'd0, o_es},    {7'd0, e.es});
        chk("err_cnt",    {7'd0, o_ec},    {7'd0, e.ec});
        chk("err_state",  {7'd0, o_est},   {7'd0, e.est});
        chk("err_count",  o_ecount,        e.ecount);
        chk("cycle_done", {7'd0, o_done},  {7'd0, e.done});
        chk("cycles",     o_cyc,           e.cyc);
    endtask

    task automatic full_cycle();
        for (int i = 0; i < md_r; i++) step(1, 2'b00, 4'(i));
        for (int i = 0; i < md_g; i++) step(1, 2'b10, 4'(i));
        for (int i = 0; i < md_y; i++) step(1, 2'b01, 4'(i));
    endtask

    initial begin
        // Reset state
        step(0, 2'b00, 4'd0);
        step(0, 2'b00, 4'd0);

        // Legal stream, three times; the first RED/0 only arms
        repeat (3) full_cycle();
        chk("stream_cycles", o_cyc, 8'd2);
        chk("stream_errcount", o_ecount, 8'd0);

        // Wrong phase after RED,2, then re-arm; err_seq stays sticky
        step(1, 2'b00, 4'd0);
        step(1, 2'b00, 4'd1);
        step(1, 2'b00, 4'd2);
        step(1, 2'b10, 4'd0);
        chk("seq_flag", {7'd0, o_es}, 8'd1);
        step(1, 2'b00, 4'd0);
        chk("seq_rearm", {7'd0, o_armed}, 8'd1);
        chk("seq_sticky", {7'd0, o_es}, 8'd1);

        // Wrong count inside RED
        step(0, 2'b00, 4'd0);
        step(1, 2'b00, 4'd0);
        step(1, 2'b00, 4'd1);
        step(1, 2'b00, 4'd3);
        chk("cnt_flag", {7'd0, o_ec}, 8'd1);
        chk("cnt_noseq", {7'd0, o_es}, 8'd0);

        // Illegal encoding while armed, then while in SYNC
        step(0, 2'b00, 4'd0);
        step(1, 2'b00, 4'd0);
        step(1, 2'b11, 4'd0);
        chk("bad_flag", {7'd0, o_est}, 8'd1);
        step(1, 2'b11, 4'd0);
        chk("bad_sync_count", o_ecount, 8'd1);

        // Reset in mid-GRN with err_cnt set and cycles==3
        step(0, 2'b00, 4'd0);
        step(1, 2'b00, 4'd0);
        step(1, 2'b00, 4'd2);
        repeat (3) full_cycle();
        step(1, 2'b00, 4'd0);
        step(1, 2'b00, 4'd1);
        step(1, 2'b00, 4'd2);
        step(1, 2'b00, 4'd3);
        step(1, 2'b00, 4'd4);
        step(1, 2'b10, 4'd0);
        step(1, 2'b10, 4'd1);
        chk("pre_rst_cycles", o_cyc, 8'd3);
        chk("pre_rst_errcnt", {7'd0, o_ec}, 8'd1);
        step(0, 2'b10, 4'd2);
        chk("rst_cycles", o_cyc, 8'd0);

        // 300 error events: err_count saturates
        for (int i = 0; i < 300; i++) begin
            step(1, 2'b00, 4'd0);
            step(1, 2'b00, 4'd3);
        end
        chk("sat_count", o_ecount, 8'd255);

        // All dwell times equal to 1
        sel = 1; md_r = 1; md_g = 1; md_y = 1;
        step(0, 2'b00, 4'd0);
        step(1, 2'b00, 4'd0);
        step(1, 2'b10, 4'd0);
        step(1, 2'b01, 4'd0);
        step(1, 2'b00, 4'd0);
        chk("dwell1_done", {7'd0, o_done}, 8'd1);
        chk("dwell1_cycles", o_cyc, 8'd1);
        chk("dwell1_errcount", o_ecount, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlc_checker.md
Name: tlc_checker

Overview:
- Passive monitor on the traffic-light controller's status interface (state[1:0], cnt[3:0]).
- Checks every cycle against the legal phase sequence RED -> GRN -> YEL -> RED and the per-phase dwell counts.
- Raises sticky error flags and keeps completed-cycle statistics.
- Instantiated next to the controller in system benches and in the top-level debug wrapper; it drives nothing back into the controller.

Parameters:
- RED_T, 5, RED dwell in clock cycles (legal 1..16)
- GRN_T, 4, GRN dwell in clock cycles (legal 1..16)
- YEL_T, 2, YEL dwell in clock cycles (legal 1..16)
- Phase encodings are fixed: RED=2'b00, YEL=2'b01, GRN=2'b10; 2'b11 is illegal.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- state  in  2  phase code from the controller
- cnt  in  4  in-phase cycle count from the controller
- armed  out  1  1 = checker is synchronised and checking
- err_seq  out  1  sticky: illegal phase transition seen
- err_cnt  out  1  sticky: correct phase but wrong cnt value seen
- err_state  out  1  sticky: state==2'b11 seen
- err_count  out  8  number of error events, saturates at 255
- cycle_done  out  1  one-cycle pulse on each legal YEL->RED transition
- cycles  out  8  completed full cycles, wraps 255->0

Behaviour:
- Reset (rst==0 sampled at posedge):
  - All outputs go to 0.
  - FSM goes to SYNC.
  - Internal prev_state/prev_cnt are cleared.
  - Reset overrides every other event in the same cycle, including mid-phase and mid-error.
- FSM states:
  - SYNC: wait for state==RED && cnt==0 at a posedge. On that edge: go to CHECK, armed=1 from the next cycle, and capture prev=(RED,0). No checks and no error flags while in SYNC.
  - CHECK: on each posedge, compute the expected sample from prev:
    - if prev_cnt < DUR(prev_state)-1: expected = (prev_state, prev_cnt+1)
    - else: expected = (next(prev_state), 0), where next(RED)=GRN, next(GRN)=YEL, next(YEL)=RED
    - DUR(RED)=RED_T, DUR(GRN)=GRN_T, DUR(YEL)=YEL_T
- Error classification (one class per sample, priority in this order):
  1. state==2'b11 -> err_state
  2. state != expected state -> err_seq
  3. cnt != expected cnt -> err_cnt
- On any error:
  - The flag is set and stays set until reset.
  - err_count increments by 1 (saturates at 255).
  - FSM returns to SYNC and armed=0 on the next cycle.
  - A later RED/0 sample re-arms the checker; flags stay sticky across the re-arm.
- On a matching sample: prev <= current sample, and FSM stays in CHECK.
- cycle_done and cycles:
  - On a matching sample where prev_state==YEL and the sample is (RED,0): cycle_done=1 for exactly one cycle and cycles increments.
  - The YEL->RED transition used to arm from SYNC does not count.
- Dwell=1 phase: cnt stays 0 for that single cycle, and the next phase follows immediately.
- cnt values >= DUR in a phase: reported as err_cnt, or err_seq if the state is also wrong.
- All outputs are registered: flags and counters update on the posedge that samples the offending or qualifying input, and are visible one cycle after the sampled input.
- No combinational path from inputs to outputs.

Test Plan:
- Correct stream, defaults, reset released then (RED,0..4),(GRN,0..3),(YEL,0..1) repeated 3 times -> armed=1 after the first RED/0 sample, no error flags, 2 cycle_done pulses (the first RED/0 arms), cycles=2, err_count=0.
- Inject (GRN,0) after (RED,2) -> err_seq=1, err_count=1, armed=0 next cycle; the following RED/0 re-arms; err_seq remains 1.
- Inject (RED,3) after (RED,1) -> err_cnt=1, err_seq=0, err_count=1.
- Drive state=2'b11 with cnt=0 while armed -> err_state=1 only, err_count=1; state=2'b11 while in SYNC -> no flag change.
- Parameters RED_T=1, GRN_T=1, YEL_T=1, stream (RED,0),(GRN,0),(YEL,0),(RED,0) -> cycle_done on the 4th sample, cycles=1, no errors.
- Assert rst=0 mid-GRN with err_cnt=1 and cycles=3 -> next cycle all outputs 0 and FSM in SYNC; force 300 errors -> err_count holds at 255.
